// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-aligned fetches, tracks in-flight requests,
// and buffers returned instructions for decode, with redirect flushing.

module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]    r_rd_ptr;
    logic [IW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)
                r_wr_ptr <= f_inc(r_wr_ptr);
            if (pop)
                r_rd_ptr <= f_inc(r_rd_ptr);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;
endmodule

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_drop;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_outstanding;
    logic [CW:0]   w_inflight;
    logic          w_fire;
    logic          w_rsp;
    logic          w_keep;
    logic          w_take;
    logic [31:0]   w_pend_pc;
    logic [63:0]   w_buf_head;

    // Buffer slots are reserved at request time, so the buffer can never overflow.
    assign w_inflight     = {1'b0, w_count} + {1'b0, w_outstanding};
    assign imem_req_valid = (w_inflight < L_DEPTH) && !redirect_valid && !rst;
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    assign w_rsp  = imem_rsp_valid && !rst;
    assign w_keep = w_rsp && (r_drop == '0) && !redirect_valid;

    assign id_valid = (w_count != '0) && !rst;
    assign w_take   = id_valid && id_ready;
    assign id_pc    = w_buf_head[63:32];
    assign id_instr = w_buf_head[31:0];

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (w_fire),
        .push_data (r_pc),
        .pop       (w_rsp),
        .head_data (w_pend_pc),
        .count     (w_outstanding)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect_valid),
        .push      (w_keep),
        .push_data ({w_pend_pc, imem_rsp_data}),
        .pop       (w_take),
        .head_data (w_buf_head),
        .count     (w_count)
    );

    // After a redirect every response still in flight belongs to the old path,
    // so drop becomes exactly what remains outstanding once this cycle settles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_drop <= '0;
        end else if (redirect_valid) begin
            r_pc   <= {redirect_pc[31:2], 2'b00};
            r_drop <= w_outstanding - CW'(w_rsp);
        end else begin
            if (w_fire)
                r_pc <= r_pc + 32'd4;
            if (w_rsp && (r_drop != '0))
                r_drop <= r_drop - 1'b1;
        end
    end
endmodule
